// File: rtl/riscv_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int BYTE_LANES = 4;
  localparam int LANE_W     = $clog2(BYTE_LANES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte shift-in: four accepted bytes form one XLEN word.
module word_assembler
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_shift_en,
  input  logic [7:0]      i_byte,
  output logic [XLEN-1:0] o_word_next,
  output logic            o_word_done
);

  // Only the three earlier bytes need storage; the fourth arrives with the write.
  logic [XLEN-9:0]   r_word;
  logic [LANE_W-1:0] r_lane;

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTE_LANES - 1);

  assign o_word_next = {i_byte, r_word};
  assign o_word_done = i_shift_en && (r_lane == LANE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_shift_en) begin
      r_word <= o_word_next[XLEN-1:8];
      r_lane <= r_lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program into instruction memory, holding the core in reset until done.
// Byte handshake: a byte transfers on a rising edge where byte_valid && byte_ready are both high.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  imem_wdata,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH_WORDS);

  loader_state_t    r_state, w_next_state;
  logic [IDX_W-1:0] r_word_idx;
  logic [LEN_W-1:0] r_len;
  logic [XLEN-1:0]  r_addr;
  logic [XLEN-1:0]  r_wdata;

  logic            w_idle_like;
  logic            w_len_bad;
  logic            w_load_go;
  logic            w_last_word;
  logic            w_shift_en;
  logic            w_word_done;
  logic [XLEN-1:0] w_word_next;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_len_bad   = (len_words == '0) || ({1'b0, len_words} > DEPTH_L);
  assign w_load_go   = start && w_idle_like && !w_len_bad;
  assign w_last_word = (r_len == (LEN_W'(r_word_idx) + LEN_W'(1)));
  assign w_shift_en  = (r_state == ST_LOAD) && byte_valid;

  word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_load_go),
    .i_shift_en  (w_shift_en),
    .i_byte      (byte_data),
    .o_word_next (w_word_next),
    .o_word_done (w_word_done)
  );

  always_comb begin
    w_next_state = r_state;
    byte_ready   = 1'b0;
    imem_we      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    core_rst     = 1'b1;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_next_state = w_len_bad ? ST_ERR : ST_LOAD;
        done     = (r_state == ST_DONE);
        err      = (r_state == ST_ERR);
        core_rst = (r_state != ST_DONE);
      end
      ST_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_word_done) w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        imem_we      = 1'b1;
        busy         = 1'b1;
        w_next_state = w_last_word ? ST_DONE : ST_LOAD;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load_go) begin
        r_word_idx <= '0;
        r_len      <= len_words;
      end else if ((r_state == ST_WRITE) && !w_last_word) begin
        r_word_idx <= r_word_idx + IDX_W'(1);
      end
      // Address and data are captured with the fourth byte and then held.
      if (w_word_done) begin
        r_addr  <= {{(XLEN - IDX_W - 2){1'b0}}, r_word_idx, 2'b00};
        r_wdata <= w_word_next;
      end
    end
  end

  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams in, observed memory writes checked against a queue.
module tb_imem_loader;
  import riscv_pkg::*;

  localparam int DEPTH_WORDS = 64;
  localparam int LEN_W       = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len_words = '0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = '0;
  logic             byte_ready;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             core_rst;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       dbg_state;

  int errors = 0;
  int checks = 0;
  int n_writes = 0;
  logic [63:0] exp_q[$];

  imem_loader #(.DEPTH_WORDS(DEPTH_WORDS), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      n_writes++;
      if (exp_q.size() == 0) check("wr_unexpected", 64'(imem_we), 64'd0);
      else check("wr_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_imem_we"},    64'(imem_we),    64'd0);
    check({tag, "_imem_addr"},  64'(imem_addr),  64'd0);
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_core_rst"},   64'(core_rst),   64'd1);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_done"},       64'(done),       64'd0);
    check({tag, "_err"},        64'(err),        64'd0);
    check({tag, "_state"},      64'(dbg_state),  64'(ST_IDLE));
  endtask

  // All drivers run at the falling edge; the DUT samples on the rising edge.
  task automatic pulse_start(input logic [LEN_W-1:0] len);
    start = 1'b1;
    len_words = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready) check("byte_ready_timeout", 64'(byte_ready), 64'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int snap;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two-word load, back-to-back bytes
    exp_q.push_back({32'h0, 32'h0050_0013});
    exp_q.push_back({32'h4, 32'h0010_0093});
    pulse_start(16'd2);
    check("load_busy", 64'(busy), 64'd1);
    check("load_core_rst", 64'(core_rst), 64'd1);
    check("load_byte_ready", 64'(byte_ready), 64'd1);
    send_word(32'h0050_0013, 0);
    check("between_words_we", 64'(imem_we), 64'd1);
    send_word(32'h0010_0093, 0);
    check("last_we_core_rst", 64'(core_rst), 64'd1);
    check("last_we_strobe", 64'(imem_we), 64'd1);
    @(negedge clk);
    check("done_core_rst", 64'(core_rst), 64'd0);
    check("done_flag", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("two_word_writes", 64'(n_writes), 64'd2);
    check("two_word_pending", 64'(exp_q.size()), 64'd0);

    // Illegal lengths: zero and one past capacity
    snap = n_writes;
    pulse_start(16'd0);
    check("len0_err", 64'(err), 64'd1);
    check("len0_done", 64'(done), 64'd0);
    check("len0_core_rst", 64'(core_rst), 64'd1);
    pulse_start(16'(DEPTH_WORDS + 1));
    check("len_over_err", 64'(err), 64'd1);
    check("len_over_busy", 64'(busy), 64'd0);
    byte_valid = 1'b1;
    byte_data = 8'hAA;
    repeat (6) @(negedge clk);
    check("err_byte_ready", 64'(byte_ready), 64'd0);
    byte_valid = 1'b0;
    check("err_no_writes", 64'(n_writes), 64'(snap));
    pulse_start(16'(DEPTH_WORDS));
    check("len_max_busy", 64'(busy), 64'd1);
    check("len_max_err", 64'(err), 64'd0);
    apply_reset();

    // Single word with 3-cycle gaps between bytes
    exp_q.push_back({32'h0, 32'hDEAD_BEEF});
    pulse_start(16'd1);
    send_word(32'hDEAD_BEEF, 3);
    check("gap_done", 64'(done), 64'd1);
    check("gap_writes", 64'(n_writes), 64'(snap + 1));
    check("gap_pending", 64'(exp_q.size()), 64'd0);

    // Reset after six bytes of a three-word load
    exp_q.push_back({32'h0, 32'h0302_0100});
    pulse_start(16'd3);
    send_word(32'h0302_0100, 0);
    send_byte(8'h04, 0);
    send_byte(8'h05, 0);
    check("mid_load_busy", 64'(busy), 64'd1);
    apply_reset();
    repeat (8) @(negedge clk);
    check("mid_rst_writes", 64'(n_writes), 64'(snap + 2));
    check("mid_rst_core_rst", 64'(core_rst), 64'd1);
    check("mid_rst_pending", 64'(exp_q.size()), 64'd0);

    // Start during LOAD is ignored; reload from DONE rewrites from address 0
    exp_q.push_back({32'h0, 32'h1122_3344});
    pulse_start(16'd1);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    pulse_start(16'd0);
    check("ignored_start_err", 64'(err), 64'd0);
    check("ignored_start_busy", 64'(busy), 64'd1);
    send_byte(8'h22, 0);
    send_byte(8'h11, 0);
    @(negedge clk);
    check("first_done", 64'(done), 64'd1);
    check("first_core_rst", 64'(core_rst), 64'd0);
    exp_q.push_back({32'h0, 32'hCAFE_F00D});
    exp_q.push_back({32'h4, 32'h8765_4321});
    pulse_start(16'd2);
    check("reload_core_rst", 64'(core_rst), 64'd1);
    check("reload_done", 64'(done), 64'd0);
    send_word(32'hCAFE_F00D, 1);
    send_word(32'h8765_4321, 0);
    @(negedge clk);
    check("reload_done_end", 64'(done), 64'd1);
    check("reload_core_rst_end", 64'(core_rst), 64'd0);
    check("reload_writes", 64'(n_writes), 64'(snap + 5));
    check("reload_pending", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, instruction-memory capacity in 32-bit words.
REQ-002 Parameter LEN_W, default 16, width of the length field.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse requesting a program load.
REQ-006 len_words  input  LEN_W  number of 32-bit words to load, sampled on start.
REQ-007 byte_valid  input  1  upstream byte available.
REQ-008 byte_data  input  8  program byte, little-endian order.
REQ-009 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 imem_addr  output  32  byte address of the word being written.
REQ-012 imem_wdata  output  32  assembled instruction word.
REQ-013 core_rst  output  1  reset to the single-cycle core; high while the program is absent or loading.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  load completed; sticky.
REQ-016 err  output  1  illegal length requested; sticky.

Function
REQ-017 FSM states: IDLE, LOAD, WRITE, DONE, ERR.
REQ-018 IDLE/DONE/ERR + start: len_words==0 or >DEPTH_WORDS -> ERR; otherwise -> LOAD with word index 0 and byte index 0, done and err cleared, core_rst=1.
REQ-019 start is ignored in LOAD and WRITE.
REQ-020 LOAD: byte_ready=1; a byte transfers only when byte_valid&&byte_ready; byte k (0..3) lands in bits [8k+7:8k].
REQ-021 Accepting byte 3 -> WRITE in the next cycle; byte index returns to 0.
REQ-022 WRITE: lasts exactly one cycle; imem_we=1, imem_addr=word_index*4, imem_wdata=assembled word; byte_ready=0.
REQ-023 Leaving WRITE: if word_index==len_words-1 -> DONE, else word_index+1 and -> LOAD.
REQ-024 Minimum throughput: 5 cycles per word (4 byte cycles plus 1 write cycle).
REQ-025 DONE: core_rst=0 starting the cycle after the final imem_we, done=1, busy=0.
REQ-026 ERR: err=1, core_rst=1, no memory writes; only start or rst exits.
REQ-027 busy=1 exactly in LOAD and WRITE.
REQ-028 imem_addr and imem_wdata are don't-care when imem_we=0, and are held at last value.
REQ-029 Word index arithmetic is unsigned, width clog2(DEPTH_WORDS); it never wraps because lengths are bounded by REQ-018.
REQ-030 byte_valid low in LOAD stalls the load indefinitely with no timeout.

Reset
REQ-031 rst asserted: state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, err=0, indices=0.
REQ-032 rst mid-load discards the partial word; words already written stay in memory; core_rst remains 1 until a later load completes.

Structure
REQ-033 Package riscv_pkg holds the FSM state encoding, XLEN=32, and the byte-lane constant 4.
REQ-034 A single sub-module word_assembler (byte shift-in, lane counter, word-complete flag) is instantiated once.
REQ-035 The loader's memory port sits upstream of instruction_mem's write side; core_rst drives the core's rst.

Verification
REQ-036 rst, then start with len_words=2 and bytes 13,00,50,00,93,00,10,00 -> writes 0x00500013 @0x0 and 0x00100093 @0x4; core_rst falls 1 cycle after the second imem_we; done=1.
REQ-037 start with len_words=0, then start with DEPTH_WORDS+1 -> err=1, core_rst=1, no imem_we pulses.
REQ-038 len_words=1 with byte_valid gaps of 3 cycles between bytes -> single write of the correct word; no byte is lost or duplicated.
REQ-039 rst asserted after 6 bytes of a 3-word load -> word 0 written, no second write; outputs match REQ-031 immediately.
REQ-040 start pulsed during LOAD, then a reload issued from DONE -> the first start is ignored; the reload drives core_rst=1 again and overwrites from address 0.
